// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared control-bit indices, MA state type and timeout length
// Used by ma_ctrl_fsm and mem_access_unit (timeout feature: MA_TIMEOUT_EN).
package pipe_ctrl_pkg;

  localparam int CTR_MEM_READ   = 0;
  localparam int CTR_MEM_WRITE  = 1;
  localparam int CTR_REG_WRITE  = 2;
  localparam int CTR_MEM_TO_REG = 3;
  localparam int CTR_BRANCH_EQ  = 4;
  localparam int CTR_BRANCH_LT  = 5;
  localparam int CTR_JUMP       = 6;
  localparam int CTR_LINK       = 7;

  localparam int MA_TIMEOUT_CYCLES = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } maState_t;

  function automatic logic isMemOp(input logic [7:0] ctr);
    return ctr[CTR_MEM_READ] | ctr[CTR_MEM_WRITE];
  endfunction

endpackage

// File: rtl/ma_ctrl_fsm.sv
// rtl/ma_ctrl_fsm.sv - memory handshake FSM with optional timeout (MA_TIMEOUT_EN)
// Drives the request/stall handshake; reports a timeout abort to the datapath.
module ma_ctrl_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic clkIn,
  input  logic resetIn,
  input  logic memOpIn,
  input  logic memAckIn,
  output logic memReqOut,
  output logic stallOut,
  output logic timeoutOut
`ifdef MA_TIMEOUT_EN
  ,
  output logic errOut
`endif
);

  maState_t state;

`ifdef MA_TIMEOUT_EN
  logic [3:0] timeoutCnt;
  logic       errReg;

  assign timeoutOut = !resetIn && (state == ST_WAIT) && !memAckIn &&
                      (timeoutCnt == 4'(MA_TIMEOUT_CYCLES - 1));
  assign errOut     = errReg;
`else
  assign timeoutOut = 1'b0;
`endif

  assign memReqOut = !resetIn && (((state == ST_IDLE) && memOpIn) || (state == ST_WAIT));
  assign stallOut  = memReqOut && !memAckIn && !timeoutOut;

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state      <= ST_IDLE;
`ifdef MA_TIMEOUT_EN
      timeoutCnt <= 4'd0;
      errReg     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (memOpIn && !memAckIn) begin
            state      <= ST_WAIT;
`ifdef MA_TIMEOUT_EN
            // The unacknowledged IDLE cycle already counts as request cycle one.
            timeoutCnt <= 4'd1;
`endif
          end
        end
        ST_WAIT: begin
          if (memAckIn || timeoutOut) begin
            state <= ST_IDLE;
          end
`ifdef MA_TIMEOUT_EN
          else begin
            timeoutCnt <= timeoutCnt + 4'd1;
          end
          if (timeoutOut) begin
            errReg <= 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MA stage: memory access, branch resolve, WB registers
// Optional access timeout with sticky errOut when MA_TIMEOUT_EN is defined.
module mem_access_unit
  import pipe_ctrl_pkg::*;
(
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [7:0]  ctrSignalsIn,
  input  logic        LessIn,
  input  logic        ZeroIn,
  input  logic [31:0] ResultIn,
  input  logic [31:0] DataIn,
  input  logic [31:0] PCRelAddrIn,
  input  logic [31:0] retAddrIn,
  input  logic [4:0]  rdIn,
  output logic        memReqOut,
  output logic        memWeOut,
  output logic [31:0] memAddrOut,
  output logic [31:0] memWDataOut,
  input  logic [31:0] memRDataIn,
  input  logic        memAckIn,
  output logic        stallOut,
  output logic        flushOut,
  output logic [31:0] targetOut,
  output logic        wbRegWriteOut,
  output logic [4:0]  wbRdOut,
  output logic [31:0] wbDataOut
`ifdef MA_TIMEOUT_EN
  ,
  output logic        errOut
`endif
);

  logic        memWrite;
  logic        regWrite;
  logic        memToReg;
  logic        branchEq;
  logic        branchLt;
  logic        jump;
  logic        link;
  logic        memOp;
  logic        taken;
  logic        timeoutHit;
  logic [31:0] wbDataNext;

  assign memWrite = ctrSignalsIn[CTR_MEM_WRITE];
  assign regWrite = ctrSignalsIn[CTR_REG_WRITE];
  assign memToReg = ctrSignalsIn[CTR_MEM_TO_REG];
  assign branchEq = ctrSignalsIn[CTR_BRANCH_EQ];
  assign branchLt = ctrSignalsIn[CTR_BRANCH_LT];
  assign jump     = ctrSignalsIn[CTR_JUMP];
  assign link     = ctrSignalsIn[CTR_LINK];
  assign memOp    = isMemOp(ctrSignalsIn);

  ma_ctrl_fsm uFsm (
    .clkIn      (clkIn),
    .resetIn    (resetIn),
    .memOpIn    (memOp),
    .memAckIn   (memAckIn),
    .memReqOut  (memReqOut),
    .stallOut   (stallOut),
    .timeoutOut (timeoutHit)
`ifdef MA_TIMEOUT_EN
    ,
    .errOut     (errOut)
`endif
  );

  // Read+write together is a write; EX/MA is frozen while stalled so these stay stable.
  assign memWeOut    = memReqOut & memWrite;
  assign memAddrOut  = ResultIn;
  assign memWDataOut = DataIn;

  assign taken     = !stallOut && ((branchEq && ZeroIn) || (branchLt && LessIn) || jump);
  assign flushOut  = taken && !resetIn;
  assign targetOut = PCRelAddrIn;

  always_comb begin
    wbDataNext = ResultIn;
    if (link) begin
      wbDataNext = retAddrIn;
    end else if (memToReg) begin
      wbDataNext = memRDataIn;
    end
  end

  // Stall or timeout abort inserts a bubble; rd/data keep their last values.
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      wbRegWriteOut <= 1'b0;
      wbRdOut       <= 5'd0;
      wbDataOut     <= 32'd0;
    end else if (stallOut || timeoutHit) begin
      wbRegWriteOut <= 1'b0;
    end else begin
      wbRegWriteOut <= regWrite && (rdIn != 5'd0);
      wbRdOut       <= rdIn;
      wbDataOut     <= wbDataNext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table and sequence bench for mem_access_unit
// Build with MA_TIMEOUT_EN defined to exercise the timeout path.
module tb_mem_access_unit;

  logic        clkIn = 1'b0;
  logic        resetIn;
  logic [7:0]  ctrSignalsIn;
  logic        LessIn;
  logic        ZeroIn;
  logic [31:0] ResultIn;
  logic [31:0] DataIn;
  logic [31:0] PCRelAddrIn;
  logic [31:0] retAddrIn;
  logic [4:0]  rdIn;
  logic        memReqOut;
  logic        memWeOut;
  logic [31:0] memAddrOut;
  logic [31:0] memWDataOut;
  logic [31:0] memRDataIn;
  logic        memAckIn;
  logic        stallOut;
  logic        flushOut;
  logic [31:0] targetOut;
  logic        wbRegWriteOut;
  logic [4:0]  wbRdOut;
  logic [31:0] wbDataOut;
`ifdef MA_TIMEOUT_EN
  logic        errOut;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clkIn = ~clkIn;

  mem_access_unit dut (
    .clkIn         (clkIn),
    .resetIn       (resetIn),
    .ctrSignalsIn  (ctrSignalsIn),
    .LessIn        (LessIn),
    .ZeroIn        (ZeroIn),
    .ResultIn      (ResultIn),
    .DataIn        (DataIn),
    .PCRelAddrIn   (PCRelAddrIn),
    .retAddrIn     (retAddrIn),
    .rdIn          (rdIn),
    .memReqOut     (memReqOut),
    .memWeOut      (memWeOut),
    .memAddrOut    (memAddrOut),
    .memWDataOut   (memWDataOut),
    .memRDataIn    (memRDataIn),
    .memAckIn      (memAckIn),
    .stallOut      (stallOut),
    .flushOut      (flushOut),
    .targetOut     (targetOut),
    .wbRegWriteOut (wbRegWriteOut),
    .wbRdOut       (wbRdOut),
    .wbDataOut     (wbDataOut)
`ifdef MA_TIMEOUT_EN
    ,
    .errOut        (errOut)
`endif
  );

  typedef struct {
    logic [7:0]  ctr;
    logic        less;
    logic        zero;
    logic [31:0] result;
    logic [31:0] data;
    logic [31:0] pcRel;
    logic [31:0] retAddr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        ack;
    logic        eReq;
    logic        eWe;
    logic        eFlush;
    logic        eRw;
    logic [4:0]  eRd;
    logic [31:0] eData;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic idleInputs();
    ctrSignalsIn = 8'h00;
    LessIn       = 1'b0;
    ZeroIn       = 1'b0;
    ResultIn     = 32'h0;
    DataIn       = 32'h0;
    PCRelAddrIn  = 32'h0;
    retAddrIn    = 32'h0;
    rdIn         = 5'd0;
    memRDataIn   = 32'h0;
    memAckIn     = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h0D, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd5, 32'hDEADBEEF, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{8'h10, 1'b0, 1'b1, 32'h77, 32'h0, 32'h40, 32'h0, 5'd3, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h77};
    vecs[2] = '{8'h10, 1'b0, 1'b0, 32'h78, 32'h0, 32'h40, 32'h0, 5'd4, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h78};
    vecs[3] = '{8'hC4, 1'b0, 1'b0, 32'h999, 32'h0, 32'h80, 32'h24, 5'd31, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 32'h24};
    vecs[4] = '{8'h04, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1234};
    vecs[5] = '{8'h20, 1'b1, 1'b0, 32'h5, 32'h0, 32'hC0, 32'h0, 5'd2, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 32'h5};
    vecs[6] = '{8'h03, 1'b0, 1'b0, 32'h200, 32'h99, 32'h0, 32'h0, 5'd6, 32'hFFFF, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 32'h200};
    vecs[7] = '{8'h20, 1'b0, 1'b1, 32'h6, 32'h0, 32'hC4, 32'h0, 5'd8, 32'h0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h6};
    vecs[8] = '{8'h8D, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h50, 5'd9, 32'h11, 1'b1,
                1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h50};
    vecs[9] = '{8'h04, 1'b0, 1'b0, 32'hCAFE, 32'h0, 32'h0, 32'h0, 5'd7, 32'hBAD, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFE};

    // Reset with a jumping load driven: request and flush must stay quiet.
    idleInputs();
    resetIn      = 1'b1;
    ctrSignalsIn = 8'h41;
    step();
    step();
    chk("rst_memReq", 32'(memReqOut), 32'd0);
    chk("rst_stall", 32'(stallOut), 32'd0);
    chk("rst_flush", 32'(flushOut), 32'd0);
    chk("rst_wbRw", 32'(wbRegWriteOut), 32'd0);
    chk("rst_wbRd", 32'(wbRdOut), 32'd0);
    chk("rst_wbData", wbDataOut, 32'd0);
`ifdef MA_TIMEOUT_EN
    chk("rst_err", 32'(errOut), 32'd0);
`endif
    resetIn = 1'b0;
    idleInputs();

    for (int i = 0; i < 10; i++) begin
      ctrSignalsIn = vecs[i].ctr;
      LessIn       = vecs[i].less;
      ZeroIn       = vecs[i].zero;
      ResultIn     = vecs[i].result;
      DataIn       = vecs[i].data;
      PCRelAddrIn  = vecs[i].pcRel;
      retAddrIn    = vecs[i].retAddr;
      rdIn         = vecs[i].rd;
      memRDataIn   = vecs[i].rdata;
      memAckIn     = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_memReq", i), 32'(memReqOut), 32'(vecs[i].eReq));
      chk($sformatf("v%0d_memWe", i), 32'(memWeOut), 32'(vecs[i].eWe));
      chk($sformatf("v%0d_stall", i), 32'(stallOut), 32'd0);
      chk($sformatf("v%0d_flush", i), 32'(flushOut), 32'(vecs[i].eFlush));
      chk($sformatf("v%0d_target", i), targetOut, vecs[i].pcRel);
      if (vecs[i].eReq) begin
        chk($sformatf("v%0d_addr", i), memAddrOut, vecs[i].result);
      end
      step();
      chk($sformatf("v%0d_wbRw", i), 32'(wbRegWriteOut), 32'(vecs[i].eRw));
      chk($sformatf("v%0d_wbRd", i), 32'(wbRdOut), 32'(vecs[i].eRd));
      chk($sformatf("v%0d_wbData", i), wbDataOut, vecs[i].eData);
    end

    // Store acked after three stall cycles; WB rd/data hold 7 / 0xCAFE meanwhile.
    idleInputs();
    ctrSignalsIn = 8'h02;
    DataIn       = 32'h55;
    ResultIn     = 32'h400;
    rdIn         = 5'd14;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("st%0d_req", k), 32'(memReqOut), 32'd1);
      chk($sformatf("st%0d_we", k), 32'(memWeOut), 32'd1);
      chk($sformatf("st%0d_stall", k), 32'(stallOut), 32'd1);
      chk($sformatf("st%0d_wdata", k), memWDataOut, 32'h55);
      chk($sformatf("st%0d_addr", k), memAddrOut, 32'h400);
      step();
      chk($sformatf("st%0d_wbRw", k), 32'(wbRegWriteOut), 32'd0);
      chk($sformatf("st%0d_wbRdHold", k), 32'(wbRdOut), 32'd7);
      chk($sformatf("st%0d_wbDataHold", k), wbDataOut, 32'hCAFE);
    end
    memAckIn = 1'b1;
    #1;
    chk("st_ack_stall", 32'(stallOut), 32'd0);
    chk("st_ack_we", 32'(memWeOut), 32'd1);
    step();
    chk("st_done_wbRw", 32'(wbRegWriteOut), 32'd0);
    chk("st_done_wbRd", 32'(wbRdOut), 32'd14);
    idleInputs();
    #1;
    chk("st_idle_req", 32'(memReqOut), 32'd0);

    // Load acked after two stall cycles: data lands the edge after ack.
    ctrSignalsIn = 8'h0D;
    ResultIn     = 32'h500;
    rdIn         = 5'd10;
    for (int k = 1; k <= 2; k++) begin
      #1;
      chk($sformatf("ld%0d_stall", k), 32'(stallOut), 32'd1);
      step();
      chk($sformatf("ld%0d_wbRw", k), 32'(wbRegWriteOut), 32'd0);
    end
    memAckIn   = 1'b1;
    memRDataIn = 32'hA5A5A5A5;
    #1;
    chk("ld_ack_stall", 32'(stallOut), 32'd0);
    step();
    chk("ld_wbRw", 32'(wbRegWriteOut), 32'd1);
    chk("ld_wbRd", 32'(wbRdOut), 32'd10);
    chk("ld_wbData", wbDataOut, 32'hA5A5A5A5);
    idleInputs();

    // Reset in the second WAIT cycle abandons the access.
    ctrSignalsIn = 8'h4D;
    rdIn         = 5'd12;
    #1;
    chk("rw_idle_flush", 32'(flushOut), 32'd0);
    step();
    step();
    resetIn = 1'b1;
    #1;
    chk("rw_req", 32'(memReqOut), 32'd0);
    chk("rw_stall", 32'(stallOut), 32'd0);
    chk("rw_flush", 32'(flushOut), 32'd0);
    step();
    resetIn      = 1'b0;
    ctrSignalsIn = 8'h00;
    #1;
    chk("rw_post_req", 32'(memReqOut), 32'd0);
    chk("rw_post_wbRw", 32'(wbRegWriteOut), 32'd0);
    chk("rw_post_wbRd", 32'(wbRdOut), 32'd0);
    chk("rw_post_wbData", wbDataOut, 32'd0);

`ifdef MA_TIMEOUT_EN
    // Never acked: stall drops on the 16th request cycle and errOut sticks.
    ctrSignalsIn = 8'h0D;
    rdIn         = 5'd13;
    ResultIn     = 32'h600;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("to%0d_req", k), 32'(memReqOut), 32'd1);
      chk($sformatf("to%0d_stall", k), 32'(stallOut), (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("to%0d_err", k), 32'(errOut), 32'd0);
      step();
    end
    ctrSignalsIn = 8'h00;
    #1;
    chk("to_err_set", 32'(errOut), 32'd1);
    chk("to_bubble", 32'(wbRegWriteOut), 32'd0);
    chk("to_idle_req", 32'(memReqOut), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("to_err_sticky%0d", k), 32'(errOut), 32'd1);
    end
    resetIn = 1'b1;
    step();
    resetIn = 1'b0;
    chk("to_err_clr", 32'(errOut), 32'd0);
`else
    // Without the timeout, WAIT persists until the ack arrives.
    ctrSignalsIn = 8'h0D;
    rdIn         = 5'd13;
    for (int k = 1; k <= 20; k++) begin
      #1;
      chk($sformatf("nt%0d_stall", k), 32'(stallOut), 32'd1);
      step();
    end
    memAckIn   = 1'b1;
    memRDataIn = 32'h0BADF00D;
    #1;
    chk("nt_ack_stall", 32'(stallOut), 32'd0);
    step();
    chk("nt_wbData", wbDataOut, 32'h0BADF00D);
    chk("nt_wbRw", 32'(wbRegWriteOut), 32'd1);
    idleInputs();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
